// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - state encoding, address constants and port helper for the 1x3 router control FSM
package router_pkg;

   localparam int NUM_PORTS = 3;
   localparam int ADDR_W    = 2;

   localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

   typedef enum logic [2:0] {
      DA  = 3'd0,
      LFD = 3'd1,
      LD  = 3'd2,
      FFS = 3'd3,
      LAF = 3'd4,
      LP  = 3'd5,
      CPE = 3'd6,
      WTE = 3'd7
   } state_e;

   // Out-of-range addresses select nothing rather than indexing past the vector.
   function automatic logic port_bit(input logic [NUM_PORTS-1:0] vec,
                                     input logic [ADDR_W-1:0]    addr);
      port_bit = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (addr == ADDR_W'(i)) port_bit = vec[i];
      end
   endfunction

endpackage

// File: rtl/router_if.sv
// rtl/router_if.sv - source / register-stage / FIFO signals seen by the router control FSM
interface router_if;
   import router_pkg::*;

   logic                  packet_valid;
   logic [ADDR_W-1:0]     datain;
   logic                  fifo_full;
   logic [NUM_PORTS-1:0]  fifo_empty;
   logic [NUM_PORTS-1:0]  soft_reset;
   logic                  parity_done;
   logic                  low_packet_valid;

   logic                  detect_add;
   logic                  lfd_state;
   logic                  ld_state;
   logic                  full_state;
   logic                  laf_state;
   logic                  rst_int_reg;
   logic                  write_enb_reg;
   logic                  busy;

   modport master (
      output packet_valid, datain, fifo_full, fifo_empty, soft_reset,
             parity_done, low_packet_valid,
      input  detect_add, lfd_state, ld_state, full_state, laf_state,
             rst_int_reg, write_enb_reg, busy
   );

   modport slave (
      input  packet_valid, datain, fifo_full, fifo_empty, soft_reset,
             parity_done, low_packet_valid,
      output detect_add, lfd_state, ld_state, full_state, laf_state,
             rst_int_reg, write_enb_reg, busy
   );

endinterface

// File: rtl/router_fsm.sv
// rtl/router_fsm.sv - Moore control FSM sequencing one packet through the register stage into a FIFO
module router_fsm
   import router_pkg::*;
(
   input  logic     clk,
   input  logic     resetn,
   router_if.slave  bus
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= DA;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      // A timeout on the port being written aborts the packet; DA has no packet to abort.
      if (state_q != DA && port_bit(bus.soft_reset, addr_q)) begin
         state_d = DA;
      end else begin
         case (state_q)
            DA: begin
               if (bus.packet_valid && bus.datain != ADDR_INVALID) begin
                  addr_d  = bus.datain;
                  state_d = port_bit(bus.fifo_empty, bus.datain) ? LFD : WTE;
               end
            end
            WTE: if (port_bit(bus.fifo_empty, addr_q)) state_d = LFD;
            LFD: state_d = LD;
            LD: begin
               if (bus.fifo_full)          state_d = FFS;
               else if (!bus.packet_valid) state_d = LP;
            end
            FFS: if (!bus.fifo_full) state_d = LAF;
            LAF: begin
               if (bus.parity_done)           state_d = DA;
               else if (bus.low_packet_valid) state_d = LP;
               else                           state_d = LD;
            end
            LP:  state_d = CPE;
            CPE: state_d = bus.fifo_full ? FFS : DA;
            default: state_d = DA;
         endcase
      end
   end

   assign bus.detect_add    = (state_q == DA);
   assign bus.lfd_state     = (state_q == LFD);
   assign bus.ld_state      = (state_q == LD);
   assign bus.full_state    = (state_q == FFS);
   assign bus.laf_state     = (state_q == LAF);
   assign bus.rst_int_reg   = (state_q == CPE);
   assign bus.write_enb_reg = (state_q == LFD) || (state_q == LD) ||
                              (state_q == LP)  || (state_q == LAF);
   assign bus.busy          = !((state_q == DA) || (state_q == LD));

endmodule

// File: tb/tb_router_fsm.sv
// tb/tb_router_fsm.sv - directed bench for router_fsm with a phase-level reference model
module tb_router_fsm;

   logic clk;
   logic resetn;
   int   n_cmp;
   int   n_bad;
   bit   chk_en;
   int   wcount;

   router_if bus ();

   router_fsm dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks the packet phase by name from the router's rules.
   string ph;
   int    maddr;

   always @(posedge clk) begin
      if (!resetn) begin
         ph    = "DA";
         maddr = 0;
      end else if (ph != "DA" && maddr < 3 && bus.soft_reset[maddr]) begin
         ph = "DA";
      end else if (ph == "DA") begin
         if (bus.packet_valid && bus.datain != 2'd3) begin
            maddr = int'(bus.datain);
            ph    = bus.fifo_empty[maddr] ? "LFD" : "WTE";
         end
      end else if (ph == "WTE") begin
         if (bus.fifo_empty[maddr]) ph = "LFD";
      end else if (ph == "LFD") begin
         ph = "LD";
      end else if (ph == "LD") begin
         if (bus.fifo_full)          ph = "FFS";
         else if (!bus.packet_valid) ph = "LP";
      end else if (ph == "FFS") begin
         if (!bus.fifo_full) ph = "LAF";
      end else if (ph == "LAF") begin
         ph = bus.parity_done ? "DA" : (bus.low_packet_valid ? "LP" : "LD");
      end else if (ph == "LP") begin
         ph = "CPE";
      end else if (ph == "CPE") begin
         ph = bus.fifo_full ? "FFS" : "DA";
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_detect_add", int'(bus.detect_add),    int'(ph == "DA"));
         check("cyc_lfd_state",  int'(bus.lfd_state),     int'(ph == "LFD"));
         check("cyc_ld_state",   int'(bus.ld_state),      int'(ph == "LD"));
         check("cyc_full_state", int'(bus.full_state),    int'(ph == "FFS"));
         check("cyc_laf_state",  int'(bus.laf_state),     int'(ph == "LAF"));
         check("cyc_rst_int",    int'(bus.rst_int_reg),   int'(ph == "CPE"));
         check("cyc_write_enb",  int'(bus.write_enb_reg),
               int'(ph == "LFD" || ph == "LD" || ph == "LP" || ph == "LAF"));
         check("cyc_busy",       int'(bus.busy),          int'(!(ph == "DA" || ph == "LD")));
         check("cyc_addr_q",     int'(dut.addr_q),        maddr);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic step_cnt();
      step(1);
      wcount += int'(bus.write_enb_reg);
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; chk_en = 1'b0;
      resetn = 1'b0;
      bus.packet_valid = 1'b0; bus.datain = 2'b00; bus.fifo_full = 1'b0;
      bus.fifo_empty = 3'b000; bus.soft_reset = 3'b000;
      bus.parity_done = 1'b0; bus.low_packet_valid = 1'b0;

      // 1 reset
      step(2);
      chk_en = 1'b1;
      check("rst_detect_add", int'(bus.detect_add), 1);
      check("rst_busy",       int'(bus.busy), 0);
      check("rst_write_enb",  int'(bus.write_enb_reg), 0);
      check("rst_lfd",        int'(bus.lfd_state), 0);
      resetn = 1'b1;
      step(1);

      // 2 normal packet to port 1
      wcount = 0;
      bus.packet_valid = 1'b1; bus.datain = 2'b01; bus.fifo_empty = 3'b111;
      step_cnt();
      check("t2_lfd", int'(bus.lfd_state), 1);
      check("t2_lfd_busy", int'(bus.busy), 1);
      for (int i = 0; i < 3; i++) begin
         step_cnt();
         check("t2_ld", int'(bus.ld_state), 1);
         if (i == 2) bus.packet_valid = 1'b0;
      end
      step_cnt();
      check("t2_lp_busy", int'(bus.busy), 1);
      step_cnt();
      check("t2_cpe", int'(bus.rst_int_reg), 1);
      step_cnt();
      check("t2_back_da", int'(bus.detect_add), 1);
      check("t2_write_cycles", wcount, 5);

      // 3 busy target waits for empty
      bus.packet_valid = 1'b1; bus.datain = 2'b10; bus.fifo_empty = 3'b011;
      step(1);
      bus.packet_valid = 1'b0;
      check("t3_wte_busy", int'(bus.busy), 1);
      check("t3_wte_we", int'(bus.write_enb_reg), 0);
      step(1);
      check("t3_wte_hold", int'(bus.detect_add | bus.lfd_state), 0);
      bus.fifo_empty = 3'b111;
      step(1);
      check("t3_lfd", int'(bus.lfd_state), 1);
      step(4);
      check("t3_da", int'(bus.detect_add), 1);

      // 4 full stall, LAF back to LD, CPE with full, LAF with parity done
      bus.packet_valid = 1'b1; bus.datain = 2'b00;
      step(3);
      bus.fifo_full = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1);
         check("t4_ffs", int'(bus.full_state), 1);
      end
      bus.fifo_full = 1'b0;
      step(1);
      check("t4_laf_we", int'(bus.write_enb_reg), 1);
      check("t4_laf_busy", int'(bus.busy), 1);
      step(1);
      check("t4_ld", int'(bus.ld_state), 1);
      bus.packet_valid = 1'b0;
      step(1);
      bus.fifo_full = 1'b1;
      step(1);
      check("t4_cpe", int'(bus.rst_int_reg), 1);
      step(1);
      check("t4_cpe_ffs", int'(bus.full_state), 1);
      bus.fifo_full = 1'b0;
      step(1);
      bus.parity_done = 1'b1;
      step(1);
      bus.parity_done = 1'b0;
      check("t4_laf_da", int'(bus.detect_add), 1);

      // 5 soft reset on other port ignored, own port aborts
      bus.packet_valid = 1'b1; bus.datain = 2'b00;
      step(2);
      bus.soft_reset = 3'b010;
      step(1);
      check("t5_other_port", int'(bus.ld_state), 1);
      bus.soft_reset = 3'b001;
      step(1);
      check("t5_own_port", int'(bus.detect_add), 1);
      bus.soft_reset = 3'b000; bus.packet_valid = 1'b0;
      step(1);
      // full beats packet_valid fall in LD; soft reset then aborts from FFS
      bus.packet_valid = 1'b1; bus.datain = 2'b01;
      step(2);
      bus.packet_valid = 1'b0; bus.fifo_full = 1'b1;
      step(1);
      check("t5_full_prio", int'(bus.full_state), 1);
      bus.soft_reset = 3'b010;
      step(1);
      check("t5_ffs_abort", int'(bus.detect_add), 1);
      bus.soft_reset = 3'b000; bus.fifo_full = 1'b0;

      // 6 invalid address dropped
      bus.packet_valid = 1'b1; bus.datain = 2'b11;
      step(2);
      check("t6_stay_da", int'(bus.detect_add), 1);
      check("t6_no_we", int'(bus.write_enb_reg), 0);
      check("t6_addr_kept", int'(dut.addr_q), 1);
      bus.packet_valid = 1'b0;
      step(1);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
